seg_disp_sched: RTL
===================

SEG_DISP_SCHED -- requirements
Module: seg_disp_sched

Interface
REQ-001 Parameter REFRESH_CYC, 24'd1_000_000, idle cycles between automatic re-sends of the current frame.
REQ-002 Parameter FLASH_DIV, 25'd25_000_000, clk cycles per half-period of the flash output.
REQ-003 Parameter WAIT_MAX, 16'd1024, max cycles in WAIT before timeout.
REQ-004 The block SHALL use one clock, clk; reset is rst, asynchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_cpu  in  1  CPU frame request, held high until ack_cpu.
REQ-008 cpu_hexs / cpu_point / cpu_les  in  32/8/8  CPU frame data, stable while req_cpu high.
REQ-009 req_dbg  in  1  debug frame request, held high until ack_dbg.
REQ-010 dbg_hexs / dbg_point / dbg_les  in  32/8/8  debug frame data.
REQ-011 shift_done  in  1  one-cycle pulse from serial shifter: frame fully shifted.
REQ-012 ack_cpu / ack_dbg  out  1  one-cycle grant pulse.
REQ-013 Start  out  1  one-cycle pulse launching a serial shift.
REQ-014 Hexs / point / LES  out  32/8/8  registered frame to display datapath.
REQ-015 flash  out  1  blink square wave.
REQ-016 busy  out  1  high in LOAD, START, WAIT.
REQ-017 src  out  1  source of current frame: 0 = CPU, 1 = debug.
REQ-018 timeout_err  out  1  sticky: a WAIT exceeded WAIT_MAX.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, START, WAIT.
REQ-020 IDLE: if any req high at an edge, SHALL grant one source, register its data into Hexs/point/LES, set src, pulse its ack for that one cycle, go LOAD.
REQ-021 Simultaneous req_cpu and req_dbg SHALL be resolved round-robin: a last-grant pointer (reset 0 = CPU last) gives the other source priority; pointer updates on every grant.
REQ-022 IDLE with no req and refresh_pend set SHALL go LOAD without changing Hexs/point/LES/src and clear refresh_pend; requests beat refresh.
REQ-023 LOAD: one cycle, data settle; -> START.
REQ-024 START: Start = 1 for exactly this cycle; -> WAIT; latency req-sampled to Start high = 2 cycles.
REQ-025 WAIT: shift_done -> IDLE; WAIT counter reaching WAIT_MAX-1 without shift_done -> IDLE and set timeout_err.
REQ-026 shift_done outside WAIT SHALL be ignored.
REQ-027 Requests arriving while busy SHALL wait (no ack) until IDLE; no request dropped.
REQ-028 Refresh counter SHALL count up only in IDLE, reset to 0 on leaving IDLE; at REFRESH_CYC-1 sets refresh_pend.
REQ-029 Flash counter SHALL run freely, toggle flash at FLASH_DIV-1 and wrap to 0, independent of FSM.
REQ-030 timeout_err SHALL clear only by rst.

Reset
REQ-031 rst high SHALL immediately force: state IDLE, Hexs 0, point 0, LES 0, src 0, Start 0, ack_cpu 0, ack_dbg 0, busy 0, flash 0, timeout_err 0, pointer 0, all counters 0, refresh_pend 0.
REQ-032 rst during LOAD/START/WAIT SHALL abort the frame; no Start pulse after rst release until a new grant.

Verification
REQ-033 req_cpu with cpu_hexs=32'h1234_5678 -> ack_cpu at edge 1, Hexs=32'h1234_5678, src=0, Start at edge 3, busy until shift_done.
REQ-034 req_cpu and req_dbg high same cycle after reset -> dbg granted first, cpu granted at first IDLE after shift_done.
REQ-035 No requests, REFRESH_CYC=16 -> after 16 idle cycles Start pulses with Hexs unchanged.
REQ-036 WAIT_MAX=8, shift_done never arrives -> returns IDLE after 8 WAIT cycles, timeout_err=1 held.
REQ-037 rst asserted in WAIT -> all outputs at reset values same cycle; shift_done after release ignored.
REQ-038 FLASH_DIV=4 -> flash toggles every 4 cycles from reset, unaffected by traffic.

Source files
------------

// File: rtl/seg_disp_if.sv
// seg_disp_if -- bundle between frame sources, scheduler and serial shifter.
// Signals:
//   req_cpu, cpu_hexs, cpu_point, cpu_les   CPU frame request and data
//   req_dbg, dbg_hexs, dbg_point, dbg_les   debug frame request and data
//   shift_done                              shifter finished a frame (pulse)
//   ack_cpu, ack_dbg                        one-cycle grant pulses
//   Start                                   one-cycle shift launch pulse
//   Hexs, point, LES                        registered frame to the datapath
//   flash, busy, src, timeout_err           status outputs
// Modports:
//   master  request/shifter side (drives requests, data, shift_done)
//   slave   scheduler side
interface seg_disp_if;
    logic        req_cpu;
    logic [31:0] cpu_hexs;
    logic [7:0]  cpu_point;
    logic [7:0]  cpu_les;
    logic        req_dbg;
    logic [31:0] dbg_hexs;
    logic [7:0]  dbg_point;
    logic [7:0]  dbg_les;
    logic        shift_done;

    logic        ack_cpu;
    logic        ack_dbg;
    logic        Start;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        flash;
    logic        busy;
    logic        src;
    logic        timeout_err;

    modport master (
        output req_cpu, cpu_hexs, cpu_point, cpu_les,
        output req_dbg, dbg_hexs, dbg_point, dbg_les,
        output shift_done,
        input  ack_cpu, ack_dbg, Start, Hexs, point, LES,
        input  flash, busy, src, timeout_err
    );

    modport slave (
        input  req_cpu, cpu_hexs, cpu_point, cpu_les,
        input  req_dbg, dbg_hexs, dbg_point, dbg_les,
        input  shift_done,
        output ack_cpu, ack_dbg, Start, Hexs, point, LES,
        output flash, busy, src, timeout_err
    );
endinterface

// File: rtl/seg_disp_sched.sv
// seg_disp_sched -- display frame scheduler.
// Grants CPU or debug frame requests (round-robin when both collide),
// registers the granted frame, launches the serial shifter with a one-cycle
// Start pulse and waits for shift_done (bounded by WAIT_MAX). After
// REFRESH_CYC idle cycles the current frame is re-sent unchanged. A free
// running divider produces the flash square wave.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  seg_disp_if.slave: requests/acks and frame data in, shifter
//        handshake, registered frame out, flash/busy/src/timeout_err
//
// state | meaning
// IDLE  | waiting for a request or a pending refresh
// LOAD  | frame registers settle for one cycle
// START | Start pulse to the shifter
// WAIT  | waiting for shift_done or the WAIT_MAX timeout
module seg_disp_sched #(
    parameter logic [23:0] REFRESH_CYC = 24'd1_000_000,
    parameter logic [24:0] FLASH_DIV   = 25'd25_000_000,
    parameter logic [15:0] WAIT_MAX    = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    seg_disp_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        grant_cpu;
    logic        grant_dbg;
    logic        grant_any;
    logic        last_dbg;

    logic [31:0] hexs_q;
    logic [7:0]  point_q;
    logic [7:0]  les_q;
    logic        src_q;
    logic        ack_cpu_q;
    logic        ack_dbg_q;

    logic [23:0] refresh_cnt;
    logic        refresh_pend;
    logic [15:0] wait_cnt;
    logic        wait_tc;
    logic        timeout_q;
    logic [24:0] flash_cnt;
    logic        flash_q;

    logic        start_o;
    logic        busy_o;

    // Grant decode: only meaningful in IDLE. On collision the source that
    // was not granted last wins.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (state == S_IDLE) begin
            if (bus.req_cpu && bus.req_dbg) begin
                if (last_dbg) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_dbg = 1'b1;
                end
            end else if (bus.req_cpu) begin
                grant_cpu = 1'b1;
            end else if (bus.req_dbg) begin
                grant_dbg = 1'b1;
            end
        end
    end

    assign grant_any = grant_cpu | grant_dbg;
    assign wait_tc   = (wait_cnt == WAIT_MAX - 16'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a request always beats a pending refresh
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_any || refresh_pend) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD:  state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.shift_done || wait_tc) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode (Moore)
    always_comb begin
        start_o = 1'b0;
        busy_o  = 1'b0;
        case (state)
            S_LOAD: begin
                busy_o = 1'b1;
            end
            S_START: begin
                start_o = 1'b1;
                busy_o  = 1'b1;
            end
            S_WAIT: begin
                busy_o = 1'b1;
            end
            default: begin
                start_o = 1'b0;
                busy_o  = 1'b0;
            end
        endcase
    end

    // Frame registers, grant pulses and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hexs_q    <= 32'd0;
            point_q   <= 8'd0;
            les_q     <= 8'd0;
            src_q     <= 1'b0;
            ack_cpu_q <= 1'b0;
            ack_dbg_q <= 1'b0;
            last_dbg  <= 1'b0;
        end else begin
            ack_cpu_q <= grant_cpu;
            ack_dbg_q <= grant_dbg;
            if (grant_cpu) begin
                hexs_q   <= bus.cpu_hexs;
                point_q  <= bus.cpu_point;
                les_q    <= bus.cpu_les;
                src_q    <= 1'b0;
                last_dbg <= 1'b0;
            end else if (grant_dbg) begin
                hexs_q   <= bus.dbg_hexs;
                point_q  <= bus.dbg_point;
                les_q    <= bus.dbg_les;
                src_q    <= 1'b1;
                last_dbg <= 1'b1;
            end
        end
    end

    // Refresh timer: counts only while staying in IDLE. A pending refresh
    // survives a request grant and is served at the next idle opportunity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt  <= 24'd0;
            refresh_pend <= 1'b0;
        end else begin
            if (state != S_IDLE || state_nxt != S_IDLE) begin
                refresh_cnt <= 24'd0;
            end else if (refresh_cnt == REFRESH_CYC - 24'd1) begin
                refresh_cnt  <= 24'd0;
                refresh_pend <= 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 24'd1;
            end
            if (state == S_IDLE && !grant_any && refresh_pend) begin
                refresh_pend <= 1'b0;
            end
        end
    end

    // WAIT timer and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_WAIT && state_nxt == S_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end else begin
                wait_cnt <= 16'd0;
            end
            if (state == S_WAIT && !bus.shift_done && wait_tc) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Flash divider, independent of the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_cnt <= 25'd0;
            flash_q   <= 1'b0;
        end else if (flash_cnt == FLASH_DIV - 25'd1) begin
            flash_cnt <= 25'd0;
            flash_q   <= ~flash_q;
        end else begin
            flash_cnt <= flash_cnt + 25'd1;
        end
    end

    assign bus.ack_cpu     = ack_cpu_q;
    assign bus.ack_dbg     = ack_dbg_q;
    assign bus.Start       = start_o;
    assign bus.Hexs        = hexs_q;
    assign bus.point       = point_q;
    assign bus.LES         = les_q;
    assign bus.flash       = flash_q;
    assign bus.busy        = busy_o;
    assign bus.src         = src_q;
    assign bus.timeout_err = timeout_q;

endmodule
